imem_fetch_arbiter: RTL and testbench

Sequencer and arbiter for the instruction memory's single read address and debug write port. It shares that memory between two users: the CPU fetch stage, which reads a 32-bit instruction plus the following one, and the debug program loader, which streams words in bursts. It owns the memory's `addr`, `dbg_wr_en`, `dbg_addr` and `dbg_instr` inputs, registers fetch responses, and stalls fetch for the full length of a load burst.

---
 rtl/imem_fetch_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter
//
// Shares the instruction memory between the CPU fetch stage and the debug
// program loader. The loader has priority: once a burst starts, fetch is
// stalled until the burst ends (last beat or idle timeout). Fetch responses
// are registered with one cycle of latency, and misaligned fetches return NOP
// with an error flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_req/addr/ready     fetch request handshake
//   fetch_valid/instr/next_instr/err
//                            registered fetch response (valid is a pulse)
//   load_valid/ready/addr/instr/last
//                            loader beat handshake
//   load_busy/err/count      loader status (err and count cover the current
//                            or most recent burst)
//   imem_addr                memory read address
//   imem_instruction/imem_next_instruction
//                            memory read data (word at addr and addr+4)
//   imem_dbg_wr_en/addr/instr
//                            memory debug write port
// ---------------------------------------------------------------------------
module imem_fetch_arbiter #(
    parameter int          XLEN    = 64,
    parameter int          TIMEOUT = 256,
    parameter logic [31:0] NOP     = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_ready,
    output logic            fetch_valid,
    output logic [31:0]     fetch_instr,
    output logic [31:0]     fetch_next_instr,
    output logic            fetch_err,

    input  logic            load_valid,
    output logic            load_ready,
    input  logic [XLEN-1:0] load_addr,
    input  logic [31:0]     load_instr,
    input  logic            load_last,
    output logic            load_busy,
    output logic            load_err,
    output logic [15:0]     load_count,

    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instruction,
    input  logic [31:0]     imem_next_instruction,
    output logic            imem_dbg_wr_en,
    output logic [XLEN-1:0] imem_dbg_addr,
    output logic [31:0]     imem_dbg_instr
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Wide enough to hold TIMEOUT itself.
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     timeout_cnt;
    logic [XLEN-1:0]   last_addr;

    logic              fetch_accept;
    logic              beat_accept;
    logic              beat_aligned;
    logic              timeout_hit;
    logic              burst_start;
    logic              timeout_abort;

    // -----------------------------------------------------------------------
    // Handshakes and the memory-facing muxes
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_ready    = !rst && (state == IDLE) && !load_valid;
        load_ready     = !rst && (state == LOAD);
        load_busy      = (state == LOAD);

        fetch_accept   = fetch_req && fetch_ready;
        beat_accept    = load_valid && load_ready;
        beat_aligned   = (load_addr[1:0] == 2'b00);

        // Misaligned beats are accepted but never written.
        imem_dbg_wr_en = beat_accept && beat_aligned;
        imem_dbg_addr  = load_addr;
        imem_dbg_instr = load_instr;

        // The memory sees the new address in the accept cycle so the
        // response can be registered on the following edge.
        imem_addr      = fetch_accept ? fetch_addr : last_addr;

        // The abort fires on the edge where the idle count would reach
        // TIMEOUT; a beat arriving in that cycle is still accepted.
        timeout_hit    = (state == LOAD) && (timeout_cnt == TW'(TIMEOUT - 1));
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt     = state;
        burst_start   = 1'b0;
        timeout_abort = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt   = LOAD;
                    burst_start = 1'b1;
                end
            end
            LOAD: begin
                if (beat_accept && load_last) begin
                    // A last beat in the timeout cycle is a normal end.
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    state_nxt     = IDLE;
                    timeout_abort = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Loader status and idle timeout
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
            load_err    <= 1'b0;
            load_count  <= 16'd0;
        end else if (burst_start) begin
            timeout_cnt <= '0;
            load_err    <= 1'b0;
            load_count  <= 16'd0;
        end else if (state == LOAD) begin
            timeout_cnt <= load_valid ? '0 : timeout_cnt + 1'b1;
            if ((beat_accept && !beat_aligned) || timeout_abort)
                load_err <= 1'b1;
            if (imem_dbg_wr_en && (load_count != 16'hFFFF))
                load_count <= load_count + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch response register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid      <= 1'b0;
            fetch_err        <= 1'b0;
            fetch_instr      <= 32'd0;
            fetch_next_instr <= 32'd0;
            last_addr        <= '0;
        end else begin
            fetch_valid <= fetch_accept;
            // Data and error hold between responses.
            if (fetch_accept) begin
                last_addr <= fetch_addr;
                if (fetch_addr[1:0] != 2'b00) begin
                    fetch_err        <= 1'b1;
                    fetch_instr      <= NOP;
                    fetch_next_instr <= NOP;
                end else begin
                    fetch_err        <= 1'b0;
                    fetch_instr      <= imem_instruction;
                    fetch_next_instr <= imem_next_instruction;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for imem_fetch_arbiter. A small behavioural memory sits on the
// imem ports. Each table row drives inputs for one cycle, checks the
// combinational handshakes before the edge and the registered outputs after
// it. A hand-written sequence then measures the timeout abort with a bounded
// wait.
// ---------------------------------------------------------------------------
module tb_imem_fetch_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_req;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [31:0]     fetch_instr;
    logic [31:0]     fetch_next_instr;
    logic            fetch_err;
    logic            load_valid;
    logic            load_ready;
    logic [XLEN-1:0] load_addr;
    logic [31:0]     load_instr;
    logic            load_last;
    logic            load_busy;
    logic            load_err;
    logic [15:0]     load_count;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_instruction;
    logic [31:0]     imem_next_instruction;
    logic            imem_dbg_wr_en;
    logic [XLEN-1:0] imem_dbg_addr;
    logic [31:0]     imem_dbg_instr;

    imem_fetch_arbiter #(
        .XLEN    (XLEN),
        .TIMEOUT (4),
        .NOP     (32'h00000013)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetch_req             (fetch_req),
        .fetch_addr            (fetch_addr),
        .fetch_ready           (fetch_ready),
        .fetch_valid           (fetch_valid),
        .fetch_instr           (fetch_instr),
        .fetch_next_instr      (fetch_next_instr),
        .fetch_err             (fetch_err),
        .load_valid            (load_valid),
        .load_ready            (load_ready),
        .load_addr             (load_addr),
        .load_instr            (load_instr),
        .load_last             (load_last),
        .load_busy             (load_busy),
        .load_err              (load_err),
        .load_count            (load_count),
        .imem_addr             (imem_addr),
        .imem_instruction      (imem_instruction),
        .imem_next_instruction (imem_next_instruction),
        .imem_dbg_wr_en        (imem_dbg_wr_en),
        .imem_dbg_addr         (imem_dbg_addr),
        .imem_dbg_instr        (imem_dbg_instr)
    );

    always #5 clk = ~clk;

    // Behavioural memory: 64 words, pre-filled with a recognisable pattern.
    logic [31:0] mem [0:63];
    logic [5:0]  rd_idx;
    logic [5:0]  rd_idx_nxt;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 + 32'(i);
    end

    always @(posedge clk) begin
        if (imem_dbg_wr_en) mem[imem_dbg_addr[7:2]] <= imem_dbg_instr;
    end

    always_comb begin
        rd_idx                = imem_addr[7:2];
        rd_idx_nxt            = rd_idx + 6'd1;
        imem_instruction      = mem[rd_idx];
        imem_next_instruction = mem[rd_idx_nxt];
    end

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        // inputs
        logic        rst;
        logic        freq;
        logic [63:0] faddr;
        logic        lv;
        logic [63:0] laddr;
        logic [31:0] linstr;
        logic        llast;
        // expected before the edge
        logic        e_fready;
        logic        e_lready;
        logic        e_wr;
        // expected after the edge
        logic        e_fvalid;
        logic        e_ferr;
        logic [31:0] e_fi;
        logic [31:0] e_fni;
        logic        e_busy;
        logic        e_lerr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [$];

    task automatic drive(input logic r, input logic fq, input logic [63:0] fa,
                         input logic lv, input logic [63:0] la,
                         input logic [31:0] li, input logic ll);
        rst        = r;
        fetch_req  = fq;
        fetch_addr = fa;
        load_valid = lv;
        load_addr  = la;
        load_instr = li;
        load_last  = ll;
    endtask

    int idle_edges;

    initial begin
        drive(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0);

        //             rst freq faddr  lv  laddr  linstr        llast fr lr wr  fv fe fi            fni           busy lerr cnt
        // reset and idle
        vecs.push_back('{1'b1,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,16'd0});
        // fetch and load raised together: load wins, 3-beat burst
        vecs.push_back('{1'b0,1'b1,64'h04,1'b1,64'h00,32'h00500093, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b1,64'h04,1'b1,64'h00,32'h00500093, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b1,64'h04,1'b1,64'h04,32'h00100113, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,16'd2});
        vecs.push_back('{1'b0,1'b1,64'h04,1'b1,64'h08,32'h002081B3, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,16'd3});
        // held fetch completes right after the burst
        vecs.push_back('{1'b0,1'b1,64'h04,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h00100113, 32'h002081B3, 1'b0,1'b0,16'd3});
        // back-to-back fetches 0x0, 0x4, 0x8
        vecs.push_back('{1'b0,1'b1,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h00500093, 32'h00100113, 1'b0,1'b0,16'd3});
        vecs.push_back('{1'b0,1'b1,64'h04,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h00100113, 32'h002081B3, 1'b0,1'b0,16'd3});
        vecs.push_back('{1'b0,1'b1,64'h08,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h002081B3, 32'hDEAD0003, 1'b0,1'b0,16'd3});
        // data hold, then misaligned fetch 0x6
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,32'h002081B3, 32'hDEAD0003, 1'b0,1'b0,16'd3});
        vecs.push_back('{1'b0,1'b1,64'h06,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,32'h00000013, 32'h00000013, 1'b0,1'b0,16'd3});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b0,1'b0,16'd3});
        // burst with a misaligned beat to 0x2, then an aligned last beat to 0xC
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h02,32'h11111111, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h02,32'h11111111, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b1,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h0C,32'h22222222, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b0,1'b1,16'd1});
        // new burst clears load_err; one beat then timeout (TIMEOUT = 4)
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h10,32'h33333333, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h10,32'h33333333, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b1,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b1,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b1,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b1,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b0,1'b1,16'd1});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,32'h00000013, 32'h00000013, 1'b0,1'b1,16'd1});
        // fetch 0xC sees the aligned write from the misaligned-beat burst
        vecs.push_back('{1'b0,1'b1,64'h0C,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h22222222, 32'h33333333, 1'b0,1'b1,16'd1});
        // timeout boundary: last beat arrives in the abort cycle
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h14,32'h44444444, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h22222222, 32'h33333333, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,32'h22222222, 32'h33333333, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,32'h22222222, 32'h33333333, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b0,64'h00,32'h0,        1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,32'h22222222, 32'h33333333, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h14,32'h44444444, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h22222222, 32'h33333333, 1'b0,1'b0,16'd1});
        vecs.push_back('{1'b0,1'b1,64'h10,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h33333333, 32'h44444444, 1'b0,1'b0,16'd1});
        // reset in the middle of a burst
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h18,32'h55555555, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h33333333, 32'h44444444, 1'b1,1'b0,16'd0});
        vecs.push_back('{1'b0,1'b0,64'h00,1'b1,64'h18,32'h55555555, 1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h33333333, 32'h44444444, 1'b1,1'b0,16'd1});
        vecs.push_back('{1'b1,1'b0,64'h00,1'b1,64'h1C,32'h66666666, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,16'd0});
        // word written before the reset is still in memory; 0x1C was not
        vecs.push_back('{1'b0,1'b1,64'h18,1'b0,64'h00,32'h0,        1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h55555555, 32'hDEAD0007, 1'b0,1'b0,16'd0});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].freq, vecs[i].faddr, vecs[i].lv,
                  vecs[i].laddr, vecs[i].linstr, vecs[i].llast);
            #1;
            check("fetch_ready",      i, 64'(fetch_ready),      64'(vecs[i].e_fready));
            check("load_ready",       i, 64'(load_ready),       64'(vecs[i].e_lready));
            check("imem_dbg_wr_en",   i, 64'(imem_dbg_wr_en),   64'(vecs[i].e_wr));
            @(posedge clk);
            #1;
            check("fetch_valid",      i, 64'(fetch_valid),      64'(vecs[i].e_fvalid));
            check("fetch_err",        i, 64'(fetch_err),        64'(vecs[i].e_ferr));
            check("fetch_instr",      i, 64'(fetch_instr),      64'(vecs[i].e_fi));
            check("fetch_next_instr", i, 64'(fetch_next_instr), 64'(vecs[i].e_fni));
            check("load_busy",        i, 64'(load_busy),        64'(vecs[i].e_busy));
            check("load_err",         i, 64'(load_err),         64'(vecs[i].e_lerr));
            check("load_count",       i, 64'(load_count),       64'(vecs[i].e_cnt));
        end

        // -------------------------------------------------------------------
        // Hand sequence: two beats to 0x20/0x24, then loader goes quiet.
        // The abort must come on exactly the 4th idle edge.
        // -------------------------------------------------------------------
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h20, 32'hAAAA0001, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h20, 32'hAAAA0001, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b1, 64'h24, 32'hAAAA0002, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0);
        check("busy_before_gap", 100, 64'(load_busy), 64'd1);
        idle_edges = 0;
        while (load_busy && idle_edges < 20) begin
            @(posedge clk);
            #1;
            idle_edges++;
        end
        check("timeout_edges", 100, 64'(idle_edges), 64'd4);
        check("timeout_busy",  100, 64'(load_busy),  64'd0);
        check("timeout_err",   100, 64'(load_err),   64'd1);
        check("timeout_count", 100, 64'(load_count), 64'd2);

        @(negedge clk);
        drive(1'b0, 1'b1, 64'h20, 1'b0, 64'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("gap_fetch_valid", 101, 64'(fetch_valid),      64'd1);
        check("gap_fetch_instr", 101, 64'(fetch_instr),      64'hAAAA0001);
        check("gap_fetch_next",  101, 64'(fetch_next_instr), 64'hAAAA0002);

        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("valid_is_pulse",  102, 64'(fetch_valid),      64'd0);
        check("hold_instr",      102, 64'(fetch_instr),      64'hAAAA0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
